// File: rtl/program_loader.sv
// program_loader: receives a byte-stream program image, packs byte pairs into
// 16-bit instruction words, writes them to the CPU instruction memory and
// releases the CPU from reset only after the trailing XOR checksum matches.
module program_loader #(
  parameter int DEPTH_WORDS = 128,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_CSUM, S_DONE, S_ERR} state_t;

  localparam logic [8:0] DEPTH_C = 9'(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        hi_q, hi_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [15:0]       im_wdata_q, im_wdata_d;
  logic              cpu_reset_n_q, cpu_reset_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hs;
  logic [7:0]        cnt_inc;

  // Ready depends only on the registered state, never on in_valid.
  assign in_ready = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_CSUM);
  assign hs       = in_valid && in_ready;
  assign cnt_inc  = 8'(cnt_q + 8'd1);

  assign im_we       = im_we_q;
  assign im_addr     = im_addr_q;
  assign im_wdata    = im_wdata_q;
  assign cpu_reset_n = cpu_reset_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

  // Next-state and registered-output computation for the load sequencer.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    csum_d        = csum_q;
    hi_d          = hi_q;
    im_we_d       = 1'b0;       // write strobe is a single-cycle pulse
    im_addr_d     = im_addr_q;
    im_wdata_d    = im_wdata_q;
    cpu_reset_n_d = cpu_reset_n_q;
    busy_d        = busy_q;
    done_d        = done_q;
    err_d         = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // Terminal states keep their status asserted until a new start.
        if (state_q == S_DONE) begin
          done_d = 1'b1; busy_d = 1'b0; cpu_reset_n_d = 1'b1;
        end else if (state_q == S_ERR) begin
          err_d = 1'b1; busy_d = 1'b0; cpu_reset_n_d = 1'b0;
        end
        if (start) begin
          len_d         = len;
          cnt_d         = 8'd0;
          csum_d        = 8'd0;
          done_d        = 1'b0;
          err_d         = 1'b0;
          busy_d        = 1'b1;
          cpu_reset_n_d = 1'b0;
          // Bad length: ERR state now, err flag raised on the following edge.
          if (len == 8'd0 || {1'b0, len} > DEPTH_C) state_d = S_ERR;
          else                                       state_d = S_HI;
        end
      end
      S_HI: if (hs) begin
        hi_d    = in_data;
        csum_d  = csum_q ^ in_data;
        state_d = S_LO;
      end
      S_LO: if (hs) begin
        csum_d     = csum_q ^ in_data;
        im_we_d    = 1'b1;
        im_addr_d  = ADDR_W'({cnt_q, 1'b0});
        im_wdata_d = {hi_q, in_data};
        cnt_d      = cnt_inc;
        state_d    = (cnt_inc == len_q) ? S_CSUM : S_HI;
      end
      S_CSUM: if (hs) begin
        busy_d = 1'b0;
        if (in_data == csum_q) begin
          state_d = S_DONE; done_d = 1'b1; cpu_reset_n_d = 1'b1;
        end else begin
          state_d = S_ERR; err_d = 1'b1; cpu_reset_n_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All state and outputs registered; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      len_q         <= 8'd0;
      cnt_q         <= 8'd0;
      csum_q        <= 8'd0;
      hi_q          <= 8'd0;
      im_we_q       <= 1'b0;
      im_addr_q     <= '0;
      im_wdata_q    <= 16'd0;
      cpu_reset_n_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      csum_q        <= csum_d;
      hi_q          <= hi_d;
      im_we_q       <= im_we_d;
      im_addr_q     <= im_addr_d;
      im_wdata_q    <= im_wdata_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: expected memory writes go into a scoreboard queue
// as stimulus is issued; a negedge monitor pops and compares on every im_we.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready, im_we, cpu_reset_n, busy, done, err;
  logic [7:0] im_addr;
  logic [15:0] im_wdata;

  int pass_cnt = 0;
  int total_cnt = 0;
  int we_cnt = 0;
  bit rdy_seen = 1'b0;
  logic [23:0] exp_q[$];   // {addr, data}

  program_loader #(.DEPTH_WORDS(128), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (in_ready) rdy_seen = 1'b1;
    if (im_we === 1'b1) begin
      we_cnt++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", im_addr, im_wdata);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({im_addr, im_wdata} === e) pass_cnt++;
        else $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                      im_addr, im_wdata, e[23:16], e[15:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0;
  endtask

  // Present one byte, optionally after an idle cycle, until it is accepted.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit hs;
    if (gap) begin in_valid = 1'b0; tick(); end
    in_valid = 1'b1; in_data = b;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = in_ready;
      tick();
    end
    if (!hs) begin
      total_cnt++;
      $display("FAIL send_timeout: got no handshake expected accept of 0x%0h", b);
    end
  endtask

  task automatic send_stream(input logic [7:0] csum, input bit gap);
    send_byte(8'h12, gap); send_byte(8'h34, gap);
    send_byte(8'hAB, gap); send_byte(8'hCD, gap);
    send_byte(csum, gap);
    in_valid = 1'b0;
  endtask

  task automatic push_both();
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h02, 16'hABCD});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, {31'd0, in_ready}, 0);
    check({tag, "_we"}, {31'd0, im_we}, 0);
    check({tag, "_addr_data"}, {8'd0, im_addr, im_wdata}, 0);
    check({tag, "_status"}, {28'd0, cpu_reset_n, busy, done, err}, 0);
  endtask

  task automatic check_status(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, cpu_reset_n, busy, done, err}, {28'd0, exp});
  endtask

  initial begin
    int w0;
    // Reset state
    tick(); tick();
    check_reset_vals("reset");
    reset = 1'b1;
    tick();

    // 1: good load, valid held high
    w0 = we_cnt;
    do_start(8'd2);
    check_status("s1_start", 4'b0100);
    check("s1_ready", {31'd0, in_ready}, 1);
    push_both();
    send_stream(8'h40, 1'b0);
    check_status("s1_done", 4'b1010);
    tick();
    check("s1_writes", we_cnt - w0, 2);

    // 2: start in DONE, bad checksum
    w0 = we_cnt;
    do_start(8'd2);
    check_status("s2_restart", 4'b0100);
    push_both();
    send_stream(8'h41, 1'b0);
    check_status("s2_err", 4'b0001);
    tick();
    check("s2_writes", we_cnt - w0, 2);

    // 3: valid toggling every other cycle
    w0 = we_cnt;
    do_start(8'd2);
    push_both();
    send_stream(8'h40, 1'b1);
    check_status("s3_done", 4'b1010);
    tick(); tick();
    check("s3_writes", we_cnt - w0, 2);

    // 4: illegal lengths 0 and 129
    w0 = we_cnt;
    rdy_seen = 1'b0;
    do_start(8'd0);
    tick();
    check_status("s4_len0", 4'b0001);
    do_start(8'd129);
    tick();
    check_status("s4_len129", 4'b0001);
    tick();
    check("s4_no_writes", we_cnt - w0, 0);
    check("s4_no_ready", {31'd0, rdy_seen}, 0);

    // 5: reset after three bytes, then a clean load
    do_start(8'd2);
    exp_q.push_back({8'h00, 16'h1234});
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'hAB, 1'b0);
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    check_reset_vals("s5_midreset");
    reset = 1'b1;
    tick();
    do_start(8'd2);
    push_both();
    send_stream(8'h40, 1'b0);
    check_status("s5_reload", 4'b1010);

    // 6: start pulsed in HI is ignored
    w0 = we_cnt;
    do_start(8'd2);
    do_start(8'd0);
    check_status("s6_ignored", 4'b0100);
    check("s6_ready", {31'd0, in_ready}, 1);
    push_both();
    send_stream(8'h40, 1'b0);
    check_status("s6_done", 4'b1010);
    tick(); tick();
    check("s6_writes", we_cnt - w0, 2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader that sits directly upstream of `cpu`. It receives a program as a byte stream over a valid/ready handshake and assembles bytes into 16-bit instruction words. It writes each word into the CPU's instruction memory through a dedicated write port and holds the CPU in reset until the whole image has been loaded and its checksum verified. The CPU is released only after a successful load.

## Interface
- `DEPTH_WORDS`, 128, instruction memory capacity in 16-bit words; maximum accepted `len`.
- `ADDR_W`, 8, width of the instruction-memory byte address; matches the CPU's 8-bit instruction address.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk`).
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
- `len`  in  8  number of instruction words to load; latched when `start` is accepted.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `im_we`  out  1  instruction-memory write strobe, one-cycle pulse per word.
- `im_addr`  out  ADDR_W  byte address of the word being written; always even.
- `im_wdata`  out  16  instruction word being written.
- `cpu_reset_n`  out  1  active-low reset driven to the CPU; 0 while loading or after an error.
- `busy`  out  1  a load is in progress.
- `done`  out  1  last load completed successfully; sticky until the next `start`.
- `err`  out  1  last load failed; sticky until the next `start`.

## Operation
- States: IDLE, HI, LO, CSUM, DONE, ERR.
- A byte transfers only when `in_valid` and `in_ready` are both 1 in the same cycle. `in_ready` = 1 only in HI, LO and CSUM.
- Stream format:
  - `len` word pairs, high byte first (`im_wdata[15:8]`), then low byte.
  - Then one checksum byte equal to the XOR of all 2·`len` payload bytes.
- IDLE, DONE or ERR with `start` = 1:
  - Latch `len`; clear the word counter and the running XOR.
  - Clear `done`/`err`; set `busy` = 1 and `cpu_reset_n` = 0.
  - If `len` = 0 or `len` > `DEPTH_WORDS`, go to ERR; otherwise go to HI.
- HI: on handshake, store the byte as the high byte, XOR it into the checksum, go to LO.
- LO: on handshake, XOR the byte into the checksum and register the write:
  - `im_addr` = 2·count (truncated to `ADDR_W`); `im_wdata` = {high, byte}.
  - Increment count.
  - Go to CSUM if the new count = `len`, else HI.
- CSUM: on handshake, compare the byte with the running XOR. Equal → DONE; unequal → ERR.
- DONE: `done` = 1, `busy` = 0, `cpu_reset_n` = 1.
- ERR: `err` = 1, `busy` = 0, `cpu_reset_n` = 0.
- `start` while `busy` = 1 is ignored.
- Words already written before an error or reset stay in memory; the loader never erases them.

## Timing
- Reset values (reset = 0 at an edge): state IDLE; `in_ready` 0, `im_we` 0, `im_addr` 0, `im_wdata` 0, `cpu_reset_n` 0, `busy` 0, `done` 0, `err` 0; counter and checksum 0.
- `in_ready` is decoded from the registered state only. It has no combinational path from `in_valid`.
- `start` accepted at edge N: `busy` = 1 and state HI/ERR from edge N; `in_ready` = 1 in the following cycle.
- LO handshake at edge N: `im_we` = 1 for exactly the cycle after edge N, with `im_addr`/`im_wdata` valid in that same cycle. At most one `im_we` pulse per word.
- Sustained throughput: one byte per cycle; a word's write is issued one cycle after its low byte.
- CSUM handshake at edge N: `done` or `err` = 1 and `busy` = 0 from edge N. On success, `cpu_reset_n` rises at edge N.
- The final word's `im_we` pulse coincides with the CSUM state. The CPU cannot leave reset before its last instruction is written.
- `in_valid` may drop at any cycle; state holds with no timeout.
- Reset asserted mid-load: next edge returns to IDLE with the reset values above; the partial stream is discarded.

## Test plan
- `len`=2; bytes 0x12,0x34,0xAB,0xCD, csum 0x40, `in_valid` held high → `im_we` pulses write addr 0x00=0x1234 and addr 0x02=0xABCD; `done`=1, `err`=0, `cpu_reset_n`=1 the cycle after the checksum byte.
- Same stream with csum 0x41 → both words written, then `err`=1, `done`=0, `cpu_reset_n` stays 0.
- `len`=2 stream with `in_valid` toggling every other cycle → identical writes, exactly two `im_we` pulses, same final state as the first scenario.
- `start` with `len`=0, then with `len`=129 → ERR one edge later, no `im_we`, `in_ready` never 1.
- Reset pulled low after 3 bytes of a `len`=2 load → all outputs at reset values next cycle; a following full load succeeds.
- `start` pulsed during the HI state → ignored. `start` pulsed in DONE → `cpu_reset_n`=0, `done`=0, new load proceeds.
